dcm_clkgen_prog: RTL and testbench

DCM_CLKGEN_PROG -- requirements
Module: dcm_clkgen_prog

---
 rtl/dcm_clkgen_prog.sv | 161 ++++++++++++++++
 tb/tb_dcm_clkgen_prog.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcm_clkgen_prog.sv
// DCM_CLKGEN dynamic reprogramming sequencer: serializes D-1 and M-1 words onto
// PROGEN/PROGDATA, issues GO, then waits for PROGDONE with a bounded timeout.
module dcm_clkgen_prog #(
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [8:0] cfg_mult,
    input  logic [8:0] cfg_div,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    output logic       prog_en,
    output logic       prog_data,
    input  logic       prog_done,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] error_code
);

    typedef enum logic [2:0] {
        StIdle,
        StLoadD,
        StGapD,
        StLoadM,
        StGapM,
        StGo,
        StWait
    } state_e;

    localparam logic [3:0]  GapLast     = 4'(GAP_CYCLES - 1);
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q;
    logic [7:0]  mult_q;
    logic [8:0]  shift_q;
    logic [3:0]  bit_cnt_q;
    logic [3:0]  gap_cnt_q;
    logic [15:0] wait_cnt_q;
    logic        cfg_ready_q;
    logic        prog_en_q;
    logic        prog_data_q;
    logic        busy_q;
    logic        done_q;
    logic        error_q;
    logic [1:0]  error_code_q;
    logic        cfg_ok;

    assign cfg_ok = (cfg_mult >= 9'd2) && (cfg_mult <= 9'd256) &&
                    (cfg_div >= 9'd1) && (cfg_div <= 9'd256);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            mult_q       <= 8'd0;
            shift_q      <= 9'd0;
            bit_cnt_q    <= 4'd0;
            gap_cnt_q    <= 4'd0;
            wait_cnt_q   <= 16'd0;
            cfg_ready_q  <= 1'b0;
            prog_en_q    <= 1'b0;
            prog_data_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            error_code_q <= 2'd0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    cfg_ready_q <= 1'b1;
                    if (cfg_valid && cfg_ready_q) begin
                        // Ready drops for one cycle so a held request is not re-accepted.
                        cfg_ready_q <= 1'b0;
                        mult_q      <= cfg_mult[7:0] - 8'd1;
                        shift_q     <= {cfg_div[7:0] - 8'd1, 1'b0};
                        if (cfg_ok) begin
                            state_q      <= StLoadD;
                            busy_q       <= 1'b1;
                            prog_en_q    <= 1'b1;
                            prog_data_q  <= 1'b1;
                            bit_cnt_q    <= 4'd0;
                            error_code_q <= 2'd0;
                        end else begin
                            error_q      <= 1'b1;
                            error_code_q <= 2'd1;
                        end
                    end
                end
                StLoadD, StLoadM: begin
                    if (bit_cnt_q == 4'd9) begin
                        state_q     <= (state_q == StLoadD) ? StGapD : StGapM;
                        prog_en_q   <= 1'b0;
                        prog_data_q <= 1'b0;
                        gap_cnt_q   <= 4'd0;
                    end else begin
                        prog_data_q <= shift_q[0];
                        shift_q     <= shift_q >> 1;
                        bit_cnt_q   <= bit_cnt_q + 4'd1;
                    end
                end
                StGapD: begin
                    if (gap_cnt_q == GapLast) begin
                        state_q     <= StLoadM;
                        prog_en_q   <= 1'b1;
                        prog_data_q <= 1'b1;
                        shift_q     <= {mult_q, 1'b1};
                        bit_cnt_q   <= 4'd0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 4'd1;
                    end
                end
                StGapM: begin
                    if (gap_cnt_q == GapLast) begin
                        state_q     <= StGo;
                        prog_en_q   <= 1'b1;
                        prog_data_q <= 1'b0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 4'd1;
                    end
                end
                StGo: begin
                    state_q    <= StWait;
                    prog_en_q  <= 1'b0;
                    wait_cnt_q <= 16'd0;
                end
                StWait: begin
                    // Success is checked first so it wins over a coincident timeout.
                    if (prog_done) begin
                        state_q     <= StIdle;
                        busy_q      <= 1'b0;
                        cfg_ready_q <= 1'b1;
                        done_q      <= 1'b1;
                    end else if (wait_cnt_q == TimeoutLast) begin
                        state_q      <= StIdle;
                        busy_q       <= 1'b0;
                        cfg_ready_q  <= 1'b1;
                        error_q      <= 1'b1;
                        error_code_q <= 2'd2;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign cfg_ready  = cfg_ready_q;
    assign prog_en    = prog_en_q;
    assign prog_data  = prog_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign error_code = error_code_q;

endmodule

// File: tb/tb_dcm_clkgen_prog.sv
// Scoreboard bench for dcm_clkgen_prog: expected PROGDATA bits and done/error
// events are queued as requests are driven and consumed by a negedge monitor.
module tb_dcm_clkgen_prog;

    localparam int unsigned GAP = 2;
    localparam int unsigned TMO = 16;

    typedef struct {
        logic       is_err;
        logic [1:0] code;
        int         lat;
    } evt_t;

    logic       clk;
    logic       rst_n;
    logic [8:0] cfg_mult;
    logic [8:0] cfg_div;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       prog_en;
    logic       prog_data;
    logic       prog_done;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] error_code;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;
    int   acc_cnt  = 0;
    int   en_cnt   = 0;
    logic exp_bits[$];
    evt_t exp_evt[$];

    dcm_clkgen_prog #(
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_mult  (cfg_mult),
        .cfg_div   (cfg_div),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .prog_en   (prog_en),
        .prog_data (prog_data),
        .prog_done (prog_done),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .error_code(error_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        evt_t ev;
        if (rst_n) begin
            if (cfg_valid && cfg_ready) begin
                acc_cyc <= cyc;
                acc_cnt <= acc_cnt + 1;
            end
            if (prog_en) begin
                en_cnt <= en_cnt + 1;
                if (exp_bits.size() > 0) check_eq("prog_data", prog_data, exp_bits.pop_front());
                else check_eq("prog_en_extra", prog_en, 1'b0);
            end else if (prog_data) begin
                check_eq("prog_data_idle", prog_data, 1'b0);
            end
            if (done || error) begin
                check_eq("done_and_error", done & error, 1'b0);
                if (exp_evt.size() > 0) begin
                    ev = exp_evt.pop_front();
                    check_eq("evt_kind", error, ev.is_err);
                    check_eq("evt_code", error_code, ev.code);
                    check_eq("evt_latency", cyc - acc_cyc, ev.lat);
                end else begin
                    check_eq("evt_extra", {done, error}, 2'b00);
                end
            end
        end
    end

    // done_wait > 0: prog_done is raised on that WAIT cycle; 0: timeout expected.
    task automatic send_req(input logic [8:0] m, input logic [8:0] d, input int done_wait,
                            output int acc);
        logic [8:0] dm1;
        logic [8:0] mm1;
        logic [7:0] dv;
        logic [7:0] mv;
        logic       ok;
        evt_t       ev;
        int         n;
        n = 0;
        while (cfg_ready !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) check_eq("ready_wait", cfg_ready, 1'b1);
        ok  = (m >= 9'd2) && (m <= 9'd256) && (d >= 9'd1) && (d <= 9'd256);
        dm1 = d - 9'd1;
        mm1 = m - 9'd1;
        dv  = dm1[7:0];
        mv  = mm1[7:0];
        if (ok) begin
            exp_bits.push_back(1'b1);
            exp_bits.push_back(1'b0);
            for (int i = 0; i < 8; i++) exp_bits.push_back(dv[i]);
            exp_bits.push_back(1'b1);
            exp_bits.push_back(1'b1);
            for (int i = 0; i < 8; i++) exp_bits.push_back(mv[i]);
            exp_bits.push_back(1'b0);
            ev.is_err = 1'b0;
            ev.code   = 2'd0;
            ev.lat    = 26 + ((done_wait > 0) ? done_wait : int'(TMO));
            if (done_wait == 0) begin
                ev.is_err = 1'b1;
                ev.code   = 2'd2;
            end
        end else begin
            ev.is_err = 1'b1;
            ev.code   = 2'd1;
            ev.lat    = 1;
        end
        exp_evt.push_back(ev);
        cfg_mult  = m;
        cfg_div   = d;
        cfg_valid = 1'b1;
        acc       = cyc;
        step();
        cfg_valid = 1'b0;
        if (ok) begin
            check_eq("busy_on_accept", busy, 1'b1);
            check_eq("code_cleared", error_code, 2'd0);
            check_eq("ready_low_busy", cfg_ready, 1'b0);
        end else begin
            check_eq("busy_invalid", busy, 1'b0);
            check_eq("code_invalid", error_code, 2'd1);
            step();
            check_eq("ready_back", cfg_ready, 1'b1);
        end
    endtask

    task automatic drive_done(input int acc, input int wait_cyc);
        while (cyc < acc + 25 + wait_cyc) step();
        prog_done = 1'b1;
        step();
        prog_done = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (!(busy === 1'b0 && cfg_ready === 1'b1) && n < limit) begin
            step();
            n++;
        end
        if (n >= limit) check_eq("idle_wait", {busy, cfg_ready}, 2'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int e0;
        int a0;
        logic [8:0] bad_m[4] = '{9'd1, 9'd5, 9'd300, 9'd7};
        logic [8:0] bad_d[4] = '{9'd5, 9'd0, 9'd5, 9'd257};

        rst_n     = 1'b0;
        cfg_mult  = 9'd0;
        cfg_div   = 9'd0;
        cfg_valid = 1'b0;
        prog_done = 1'b0;
        #23;
        check_eq("rst_prog_en", prog_en, 1'b0);
        check_eq("rst_prog_data", prog_data, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_error", error, 1'b0);
        check_eq("rst_error_code", error_code, 2'd0);
        step();
        rst_n = 1'b1;
        step();
        check_eq("ready_after_rst", cfg_ready, 1'b1);

        // M=25, D=1, PROGDONE on 3rd WAIT cycle
        e0 = en_cnt;
        send_req(9'd25, 9'd1, 3, acc);
        drive_done(acc, 3);
        wait_idle(20);
        check_eq("en_cycles_25_1", en_cnt - e0, 21);
        check_eq("code_after_done", error_code, 2'd0);

        // Extreme values: both words all ones
        e0 = en_cnt;
        send_req(9'd256, 9'd256, 1, acc);
        drive_done(acc, 1);
        wait_idle(20);
        check_eq("en_cycles_256", en_cnt - e0, 21);

        for (int i = 0; i < 4; i++) begin
            e0 = en_cnt;
            send_req(bad_m[i], bad_d[i], 0, acc);
            step();
            step();
            check_eq("code_hold_inv", error_code, 2'd1);
            check_eq("no_prog_en_inv", en_cnt - e0, 0);
        end

        // Timeout, with prog_done pulsed outside WAIT (must be ignored)
        send_req(9'd5, 9'd3, 0, acc);
        prog_done = 1'b1;
        while (cyc < acc + 21) step();
        prog_done = 1'b0;
        wait_idle(80);
        step();
        check_eq("code_hold_tmo", error_code, 2'd2);

        // New request attempted during LOAD_M must be ignored
        send_req(9'd9, 9'd2, 2, acc);
        a0 = acc_cnt;
        while (cyc < acc + 14) step();
        cfg_mult = 9'd77;
        cfg_div  = 9'd5;
        for (int i = 0; i < 6; i++) begin
            cfg_valid = ~cfg_valid;
            step();
        end
        cfg_valid = 1'b0;
        check_eq("no_accept_busy", acc_cnt - a0, 0);
        drive_done(acc, 2);
        wait_idle(20);
        send_req(9'd77, 9'd5, 4, acc);
        drive_done(acc, 4);
        wait_idle(20);

        // Reset in the 5th LOAD_M cycle aborts the sequence
        send_req(9'd10, 9'd4, 2, acc);
        while (cyc < acc + 17) step();
        check_eq("prog_en_before_rst", prog_en, 1'b1);
        #2;
        rst_n = 1'b0;
        exp_bits.delete();
        exp_evt.delete();
        #1;
        check_eq("midrst_prog_en", prog_en, 1'b0);
        check_eq("midrst_prog_data", prog_data, 1'b0);
        check_eq("midrst_busy", busy, 1'b0);
        check_eq("midrst_done", done, 1'b0);
        check_eq("midrst_error", error, 1'b0);
        check_eq("midrst_code", error_code, 2'd0);
        e0 = en_cnt;
        step();
        step();
        rst_n = 1'b1;
        step();
        check_eq("ready_after_midrst", cfg_ready, 1'b1);
        for (int i = 0; i < 40; i++) step();
        check_eq("no_en_after_rst", en_cnt - e0, 0);

        send_req(9'd3, 9'd2, 1, acc);
        drive_done(acc, 1);
        wait_idle(20);
        step();
        check_eq("bits_left", exp_bits.size(), 0);
        check_eq("evts_left", exp_evt.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
